// File: rtl/score_keeper.sv
// Match score keeper: IDLE/PLAY/PAUSE/OVER sequencing, goal counting from toggle inputs, winner flags.
// Define SCORE_BCD_EN to present the scores as two BCD digits instead of plain binary.
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       blue_score_up,
  input  logic       red_score_up,
  output logic       game_initiated,
  output logic       game_over,
  output logic [7:0] blue_score,
  output logic [7:0] red_score,
  output logic [1:0] winner,
  output logic       goal_pulse
);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_t;

  localparam logic [7:0]  WIN        = 8'(WIN_SCORE);
  localparam logic [31:0] PAUSE_LAST = 32'(PAUSE_CYCLES - 1);

  state_t      state;
  logic        blue_prev, red_prev, start_prev;
  logic [31:0] pause_cnt;
  logic [7:0]  blue_bin, red_bin;

  logic        blue_goal, red_goal, start_rise;
  logic        inc_blue, inc_red, clear_scores;
  logic [7:0]  blue_next, red_next;

  // Binary counts are kept in every build; they are the reference for the win comparison.
  always_comb begin
    blue_goal    = blue_score_up ^ blue_prev;
    red_goal     = red_score_up ^ red_prev;
    start_rise   = start_btn & ~start_prev;
    inc_blue     = (state == PLAY) && blue_goal && (blue_bin != WIN);
    inc_red      = (state == PLAY) && red_goal && (red_bin != WIN);
    clear_scores = (state == OVER) && start_rise;
    blue_next    = blue_bin + {7'd0, inc_blue};
    red_next     = red_bin + {7'd0, inc_red};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      blue_prev      <= 1'b0;
      red_prev       <= 1'b0;
      start_prev     <= 1'b0;
      pause_cnt      <= 32'd0;
      blue_bin       <= 8'd0;
      red_bin        <= 8'd0;
      game_initiated <= 1'b0;
      game_over      <= 1'b0;
      winner         <= 2'b00;
      goal_pulse     <= 1'b0;
    end else begin
      blue_prev  <= blue_score_up;
      red_prev   <= red_score_up;
      start_prev <= start_btn;
      goal_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            state          <= PLAY;
            game_initiated <= 1'b1;
          end
        end
        PLAY: begin
          if (blue_goal || red_goal) begin
            blue_bin       <= blue_next;
            red_bin        <= red_next;
            goal_pulse     <= 1'b1;
            game_initiated <= 1'b0;
            if (blue_next == WIN || red_next == WIN) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= {red_next == WIN, blue_next == WIN};
            end else begin
              state     <= PAUSE;
              pause_cnt <= 32'd0;
            end
          end
        end
        PAUSE: begin
          if (pause_cnt == PAUSE_LAST) begin
            state          <= PLAY;
            game_initiated <= 1'b1;
          end else begin
            pause_cnt <= pause_cnt + 32'd1;
          end
        end
        OVER: begin
          if (start_rise) begin
            state          <= PLAY;
            game_initiated <= 1'b1;
            game_over      <= 1'b0;
            winner         <= 2'b00;
            blue_bin       <= 8'd0;
            red_bin        <= 8'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCORE_BCD_EN
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Decimal display counters step alongside the binary counts, so no divider is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blue_score <= 8'h00;
      red_score  <= 8'h00;
    end else if (clear_scores) begin
      blue_score <= 8'h00;
      red_score  <= 8'h00;
    end else begin
      if (inc_blue) blue_score <= bcd_inc(blue_score);
      if (inc_red)  red_score  <= bcd_inc(red_score);
    end
  end
`else
  assign blue_score = blue_bin;
  assign red_score  = red_bin;
  logic unused_clear;
  assign unused_clear = clear_scores;
`endif

endmodule
